simple_dma_controller: RTL

Memory-side responder for the peripheral DMA protocol. It accepts a block request from a DMA device (`dma_rqst`, `dma_rd_wr`, `dma_start_address`, `dma_num_words`) and paces each word with the device's `dev_ack`. It moves data between the device and the openMSP430 DMA memory port, one word per handshake. It reports per-word completion with `dma_ack` and block completion or failure with `dma_end_flag` or `dma_error_flag`.

---
 rtl/simple_dma_controller.sv | 135 +++++++++++++
 1 files changed

// File: rtl/simple_dma_controller.sv
// Memory-side responder for the peripheral DMA protocol: paces one word per
// device handshake between a DMA device and the openMSP430 DMA memory port.
module simple_dma_controller #(
  parameter int   TIMEOUT_CYC = 16,
  parameter logic DMA_PRIO    = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dma_rqst,
  input  logic        dma_rd_wr,
  input  logic [15:0] dma_start_address,
  input  logic [15:0] dma_num_words,
  input  logic        dev_ack,
  input  logic [15:0] dev_out,
  output logic [15:0] dev_in,
  output logic        dma_ack,
  output logic        dma_end_flag,
  output logic        dma_error_flag,
  output logic [14:0] dma_addr,
  output logic [15:0] dma_din,
  output logic        dma_en,
  output logic [1:0]  dma_we,
  output logic        dma_priority,
  input  logic [15:0] dma_dout,
  input  logic        dma_ready,
  input  logic        dma_resp
);
  localparam int              TW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]   TO_LAST = TW'(TIMEOUT_CYC - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WAIT_DEV = 3'd1;
  localparam logic [2:0] S_ACCESS   = 3'd2;
  localparam logic [2:0] S_RDATA    = 3'd3;
  localparam logic [2:0] S_ACK      = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;
  localparam logic [2:0] S_ERROR    = 3'd6;

  logic [2:0]    state_q,  state_d;
  logic [14:0]   addr_q,   addr_d;
  logic [15:0]   cnt_q,    cnt_d;
  logic          dir_q,    dir_d;
  logic [15:0]   wdata_q,  wdata_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [15:0]   dev_in_q, dev_in_d;

  // Byte addressing: the low address bit carries no information for word moves.
  logic unused_addr_lsb;
  assign unused_addr_lsb = dma_start_address[0];

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    wdata_d  = wdata_q;
    to_cnt_d = to_cnt_q;
    dev_in_d = dev_in_q;
    case (state_q)
      S_IDLE: begin
        if (dma_rqst) begin
          addr_d  = dma_start_address[15:1];
          cnt_d   = dma_num_words;
          dir_d   = dma_rd_wr;
          state_d = (dma_num_words == 16'd0) ? S_DONE : S_WAIT_DEV;
        end
      end
      S_WAIT_DEV: begin
        if (!dma_rqst) begin
          state_d = S_IDLE;
        end else if (dev_ack) begin
          state_d  = S_ACCESS;
          to_cnt_d = '0;
          if (!dir_q) wdata_d = dev_out;
        end
      end
      S_ACCESS: begin
        // Request withdrawal is not checked here; the memory access must finish.
        if (dma_ready) begin
          if (dma_resp)   state_d = S_ERROR;
          else if (dir_q) state_d = S_RDATA;
          else            state_d = S_ACK;
        end else if (to_cnt_q == TO_LAST) begin
          state_d = S_ERROR;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end
      S_RDATA: begin
        dev_in_d = dma_dout;
        state_d  = S_ACK;
      end
      S_ACK: begin
        addr_d  = addr_q + 15'd1;
        cnt_d   = cnt_q - 16'd1;
        state_d = (cnt_q == 16'd1) ? S_DONE : S_WAIT_DEV;
      end
      S_DONE, S_ERROR: begin
        if (!dma_rqst) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      dir_q    <= 1'b0;
      wdata_q  <= '0;
      to_cnt_q <= '0;
      dev_in_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      wdata_q  <= wdata_d;
      to_cnt_q <= to_cnt_d;
      dev_in_q <= dev_in_d;
    end
  end

  // Every output is a decode of registered state, never of an input.
  assign dev_in         = dev_in_q;
  assign dma_ack        = (state_q == S_ACK);
  assign dma_end_flag   = (state_q == S_DONE);
  assign dma_error_flag = (state_q == S_ERROR);
  assign dma_en         = (state_q == S_ACCESS);
  assign dma_we         = (state_q == S_ACCESS && !dir_q) ? 2'b11 : 2'b00;
  assign dma_addr       = addr_q;
  assign dma_din        = wdata_q;
  assign dma_priority   = DMA_PRIO;
endmodule
